stall_ctrl: RTL and testbench
=============================

Name: stall_ctrl

Overview:
- Pipeline stall/flush controller for the five-stage core.
- Merges the decode-stage load-use stall request with multi-cycle execute operations (multiply-accumulate, divide) that it times itself.
- Drives the 6-bit per-stage stall vector: pc, if, id, ex, mem, wb.
- Sits beside the decode and execute stages; consumed by pc_reg and all pipeline registers.

Parameters:
- MADD_CYCLES, 2, busy cycles for madd/msub kind.
- DIV_CYCLES, 32, busy cycles for div/divu kind.
- CNT_W, 6, countdown counter width; must hold max(MADD_CYCLES, DIV_CYCLES)-1.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low; synchronous deassert handled upstream.
- stallreq_id_i  in  1  load-use hazard request from decode, combinational, level.
- ex_start_i  in  1  multi-cycle op present in execute, level; held until done_o seen.
- ex_kind_i  in  2  00 none, 01 madd/msub, 10 div, 11 reserved.
- flush_i  in  1  exception/redirect flush, level, one cycle.
- stall_o  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
- ex_done_o  out  1  registered; result of the multi-cycle op is valid this cycle.
- flush_o  out  1  flush to all pipeline registers.
- busy_o  out  1  FSM not IDLE.
- perf_id_cnt_o  out  32  ID stall cycle count (optional feature).
- perf_ex_cnt_o  out  32  EX stall cycle count (optional feature).

Behaviour:
- Reset (rst=0, asynchronous): FSM IDLE, counter 0, ex_done_o 0, perf counters 0. Combinational outputs reach 0 because their inputs are gated by reset.
- Stall vector constants: STALL_NONE = 000000; STALL_ID = 000111; STALL_EX = 001111.
- Combinational stall_o priority:
  - flush_i=1 → STALL_NONE.
  - else (IDLE and ex_start_i and kind 01/10) or BUSY → STALL_EX.
  - else stallreq_id_i → STALL_ID.
  - else STALL_NONE.
- flush_o = flush_i, combinational, gated by reset.
- IDLE:
  - ex_start_i=1 with kind 01/10 → load counter = N-1, where N is MADD_CYCLES or DIV_CYCLES; next state BUSY.
  - kind 00/11 → ignored; no stall, stay IDLE.
- BUSY:
  - counter != 0 → decrement.
  - counter == 0 → next state DONE; ex_done_o <= 1.
- DONE:
  - ex_done_o = 1 for exactly this cycle.
  - EX stall released; ID stall may still apply.
  - Next state IDLE unconditionally.
  - ex_start_i still high in DONE does not restart the FSM.
- Latency: a kind-N op stalls for exactly N+1 cycles (start cycle plus N BUSY cycles); ex_done_o follows in the next cycle.
- Back-to-back ops: a new start is accepted in IDLE one cycle after DONE.
- flush_i in any state → next state IDLE, counter 0, ex_done_o 0 next cycle; the aborted op never raises done.
- flush_i coinciding with DONE → done still shows this cycle, IDLE next.
- Simultaneous stallreq_id_i with EX busy → STALL_EX wins; the ID request is re-evaluated after release.
- Reset mid-BUSY → immediate IDLE, stall_o 0, no done.
- Counter never wraps: decrement only when nonzero.

Optional Feature:
- Macro: STALL_CTRL_PERF_EN.
- Defined:
  - perf_id_cnt_o increments on each cycle where stall_o == STALL_ID.
  - perf_ex_cnt_o increments on each cycle where stall_o == STALL_EX.
  - Both are 32-bit, saturate at FFFFFFFF, and clear on reset only.
- Undefined: both ports driven constant 0; no counter flops are synthesized.

Decomposition:
- Shared defines: stall vector constants STALL_NONE/STALL_ID/STALL_EX; ex_kind codes KIND_NONE/KIND_MADD/KIND_DIV; FSM state encodings ST_IDLE/ST_BUSY/ST_DONE; StallBus width 6.
- One sub-module: stall_cnt, a loadable saturating-at-zero countdown counter with load, dec and zero flag; the FSM lives in stall_ctrl.

Test Plan:
- Reset: hold rst=0 with all inputs 1 → stall_o=000000, ex_done_o=0, busy_o=0; release → remains idle.
- Load-use: stallreq_id_i=1 for 1 cycle → stall_o=000111 that cycle only, then 000000.
- Divide: ex_start_i=1, kind=10, DIV_CYCLES=32 → stall_o=001111 for 33 cycles, ex_done_o=1 on cycle 34 with stall_o=000000, busy_o=0 on cycle 35.
- Madd with concurrent ID request: kind=01, stallreq_id_i=1 throughout → 001111 for 3 cycles, then 000111; ex_done_o=1 on cycle 4.
- Flush mid-divide: flush_i=1 at BUSY counter=10 → that cycle stall_o=000000, flush_o=1; next cycle IDLE; ex_done_o never asserts.
- Perf (macro defined): 5 ID-stall cycles and one madd → perf_id_cnt_o=5, perf_ex_cnt_o=3; with the macro undefined both read 0.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg: stall vector constants, execute-op kind codes and FSM states shared by the stall controller.
package stall_ctrl_pkg;
   localparam int STALL_W = 6;
   localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
   localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
   localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
   localparam logic [1:0] KIND_NONE = 2'b00;
   localparam logic [1:0] KIND_MADD = 2'b01;
   localparam logic [1:0] KIND_DIV  = 2'b10;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;
   function automatic logic kind_valid(input logic [1:0] k);
      return k == KIND_MADD || k == KIND_DIV;
   endfunction
endpackage

// File: rtl/stall_cnt.sv
// stall_cnt: loadable countdown counter that holds at zero, with clear and zero flag.
module stall_cnt #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (dec && cnt != '0) cnt <= cnt - 1'b1;
   assign zero = cnt == '0;
endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall/flush controller merging load-use stalls with self-timed multi-cycle execute ops.
// Optional perf counters enabled by defining STALL_CTRL_PERF_EN.
module stall_ctrl
   import stall_ctrl_pkg::*;
#(
   parameter int MADD_CYCLES = 2,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stallreq_id_i,
   input  logic               ex_start_i,
   input  logic [1:0]         ex_kind_i,
   input  logic               flush_i,
   output logic [STALL_W-1:0] stall_o,
   output logic               ex_done_o,
   output logic               flush_o,
   output logic               busy_o,
   output logic [31:0]        perf_id_cnt_o,
   output logic [31:0]        perf_ex_cnt_o
);
   state_t state, state_nx;
   logic ex_req, load, dec, zero, done_nx;
   logic [CNT_W-1:0] load_val;
   assign ex_req   = ex_start_i && kind_valid(ex_kind_i);
   assign load_val = (ex_kind_i == KIND_DIV) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MADD_CYCLES - 1);
   stall_cnt #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush_i),
      .load     (load),
      .dec      (dec),
      .load_val (load_val),
      .zero     (zero)
   );
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      dec      = 1'b0;
      done_nx  = 1'b0;
      case (state)
         ST_IDLE: if (ex_req) begin
            load     = 1'b1;
            state_nx = ST_BUSY;
         end
         ST_BUSY: begin
            dec      = 1'b1;
            state_nx = zero ? ST_DONE : ST_BUSY;
            done_nx  = zero;
         end
         default: state_nx = ST_IDLE;
      endcase
      if (flush_i) begin
         state_nx = ST_IDLE;
         load     = 1'b0;
         done_nx  = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state     <= ST_IDLE;
         ex_done_o <= 1'b0;
      end else begin
         state     <= state_nx;
         ex_done_o <= done_nx;
      end
   // Combinational outputs are gated by reset so they read zero while rst is low.
   assign stall_o = (!rst || flush_i) ? STALL_NONE :
                    (state == ST_BUSY || (state == ST_IDLE && ex_req)) ? STALL_EX :
                    stallreq_id_i ? STALL_ID : STALL_NONE;
   assign flush_o = rst && flush_i;
   assign busy_o  = rst && state != ST_IDLE;
`ifdef STALL_CTRL_PERF_EN
   logic [31:0] id_cnt, ex_cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         id_cnt <= '0;
         ex_cnt <= '0;
      end else begin
         if (stall_o == STALL_ID && id_cnt != 32'hFFFF_FFFF) id_cnt <= id_cnt + 1'b1;
         if (stall_o == STALL_EX && ex_cnt != 32'hFFFF_FFFF) ex_cnt <= ex_cnt + 1'b1;
      end
   assign perf_id_cnt_o = id_cnt;
   assign perf_ex_cnt_o = ex_cnt;
`else
   assign perf_id_cnt_o = '0;
   assign perf_ex_cnt_o = '0;
`endif
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: scoreboard bench for stall_ctrl; directed plan sequences then randomized traffic vs an op-timeline model.
module tb_stall_ctrl;
   logic clk = 1'b0;
   logic rst, stallreq_id_i, ex_start_i, flush_i;
   logic [1:0] ex_kind_i;
   logic [5:0] stall_o;
   logic ex_done_o, flush_o, busy_o;
   logic [31:0] perf_id_cnt_o, perf_ex_cnt_o;

   typedef struct {
      logic [5:0]  stall;
      logic        flush, busy, done;
      logic [31:0] pid, pex;
   } exp_t;

   exp_t sq[$];
   int checks = 0, failures = 0;
   int cyc = 0, op_s = -1, op_n = 0;
   logic [31:0] pid = 0, pex = 0;

   stall_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .stallreq_id_i (stallreq_id_i),
      .ex_start_i    (ex_start_i),
      .ex_kind_i     (ex_kind_i),
      .flush_i       (flush_i),
      .stall_o       (stall_o),
      .ex_done_o     (ex_done_o),
      .flush_o       (flush_o),
      .busy_o        (busy_o),
      .perf_id_cnt_o (perf_id_cnt_o),
      .perf_ex_cnt_o (perf_ex_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   // Model: an accepted op of length n starting at cycle s stalls EX on s..s+n,
   // is busy on s+1..s+n+1 and raises done at s+n+1; a flush aborts it.
   task automatic step(input logic r, input logic id, input logic st, input logic [1:0] k, input logic fl);
      exp_t e;
      logic in_op, ex_req;
      int ph;
      rst = r; stallreq_id_i = id; ex_start_i = st; ex_kind_i = k; flush_i = fl;
      e = '{stall: 6'b0, flush: 1'b0, busy: 1'b0, done: 1'b0, pid: 32'b0, pex: 32'b0};
      if (!r) begin
         op_s = -1; pid = 0; pex = 0;
      end else begin
         in_op  = op_s >= 0;
         ph     = cyc - op_s;
         ex_req = st && (k == 2'b01 || k == 2'b10);
         e.done  = in_op && ph == op_n + 1;
         e.busy  = in_op && ph >= 1;
         e.flush = fl;
         e.stall = fl ? 6'b000000 :
                   ((in_op && ph <= op_n) || (!in_op && ex_req)) ? 6'b001111 :
                   id ? 6'b000111 : 6'b000000;
`ifdef STALL_CTRL_PERF_EN
         e.pid = pid; e.pex = pex;
         if (e.stall == 6'b000111 && pid != 32'hFFFF_FFFF) pid++;
         if (e.stall == 6'b001111 && pex != 32'hFFFF_FFFF) pex++;
`endif
         if (!in_op && ex_req && !fl) begin
            op_s = cyc;
            op_n = (k == 2'b10) ? 32 : 2;
         end else if (in_op && (fl || e.done)) op_s = -1;
      end
      sq.push_back(e);
      @(posedge clk); #1;
      cyc++;
   endtask

   always @(negedge clk) begin
      if (sq.size() != 0) begin
         exp_t e;
         e = sq.pop_front();
         chk("stall_o", 32'(stall_o), 32'(e.stall));
         chk("flush_o", 32'(flush_o), 32'(e.flush));
         chk("busy_o", 32'(busy_o), 32'(e.busy));
         chk("ex_done_o", 32'(ex_done_o), 32'(e.done));
         chk("perf_id", perf_id_cnt_o, e.pid);
         chk("perf_ex", perf_ex_cnt_o, e.pex);
      end
   end

   initial begin
      rst = 1'b0; stallreq_id_i = 1'b1; ex_start_i = 1'b1; ex_kind_i = 2'b10; flush_i = 1'b1;
      @(posedge clk); #1;
      repeat (3) step(0, 1, 1, 2'b10, 1);
      repeat (3) step(1, 0, 0, 2'b00, 0);
      step(1, 1, 0, 2'b00, 0);
      repeat (2) step(1, 0, 0, 2'b00, 0);
      repeat (34) step(1, 0, 1, 2'b10, 0);
      repeat (3) step(1, 0, 0, 2'b00, 0);
      repeat (4) step(1, 1, 1, 2'b01, 0);
      repeat (2) step(1, 1, 0, 2'b00, 0);
      step(1, 0, 0, 2'b00, 0);
      repeat (22) step(1, 0, 1, 2'b10, 0);
      step(1, 0, 0, 2'b10, 1);
      repeat (40) step(1, 0, 0, 2'b00, 0);
      repeat (5) step(1, 0, 1, 2'b11, 0);
      repeat (10) step(1, 0, 1, 2'b01, 0);
      repeat (12) step(1, 0, 1, 2'b10, 0);
      step(0, 1, 1, 2'b10, 0);
      step(1, 0, 0, 2'b00, 0);
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] rr, rf, rs;
         rr = 4'($urandom); rf = 4'($urandom); rs = 4'($urandom);
         step(rr != 0 || i < 5, ($urandom & 3) == 0, rs > 4, 2'($urandom), rf == 0);
      end
      step(1, 0, 0, 2'b00, 0);
      @(negedge clk); #1;
      chk("queue_drained", 32'(sq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
